ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the reverse direction of the keyboard and mouse receivers.
- Sends one command byte (LED set 0xED, reset 0xFF, mouse enable 0xF4, ...) to a PS/2 device over the shared open-drain clock/data pair.
- Instanced next to each PS/2 receiver. The top level merges the *_oe outputs into the existing inout pins; a line is driven low when its oe=1, otherwise high-Z.
- Driven by a ZX-Uno register write strobe or by init logic.

Parameters:
- CLK_KHZ, 28000, system clock frequency in kHz
- INHIBIT_US, 120, time the host holds clock low before the start bit
- START_TIMEOUT_MS, 15, maximum wait for the device's first clock falling edge
- XFER_TIMEOUT_MS, 2, maximum time from first falling edge to ack
- FILTER_LEN, 8, consecutive equal samples required to accept a clock level change

Ports:
- clk  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- din  in  8  byte to transmit
- send  in  1  one-cycle start strobe
- ps2clk_in  in  1  raw clock pin level
- ps2data_in  in  1  raw data pin level
- ps2clk_oe  out  1  1 = pull clock low
- ps2data_oe  out  1  1 = pull data low
- busy  out  1  transfer in progress; paired receiver ignores the line while high
- done  out  1  one-cycle pulse, byte acknowledged
- error  out  1  one-cycle pulse, transfer failed
- errcode  out  2  00 none, 01 start timeout, 10 transfer timeout, 11 no ack; held until next send

Behaviour:
- Reset (async): both oe=0, busy=0, done=0, error=0, errcode=00, FSM=IDLE. Reset mid-transfer releases both lines on the same edge, with no glitch to low.
- Input conditioning:
  - Both inputs pass through a 2-flop synchroniser.
  - Clock is also deglitched: filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge (fall) is a one-cycle pulse on filtered 1->0.
- IDLE: on send, latch din, compute odd parity p = ~^din, clear errcode, enter INHIBIT. busy rises the cycle after send. send while busy=1 is ignored.
- INHIBIT: clock_oe=1 for INHIBIT_US*CLK_KHZ/1000 cycles (3360). Then data_oe=1 (start bit), and one cycle later clock_oe=0. Enter WAIT_FIRST with the timeout counter cleared.
- WAIT_FIRST: on fall, set data_oe=~din[0], bitcnt=1, arm the transfer timer, enter SHIFT. If START_TIMEOUT_MS elapses (420000 cycles) with no fall, go to FAIL with code 01.
- SHIFT, on each fall:
  - bitcnt 1..7: data_oe=~din[bitcnt].
  - bitcnt 8: data_oe=~p.
  - bitcnt 9: data_oe=0 (stop bit).
  - bitcnt 10: enter ACK.
  - bitcnt increments per fall.
- ACK: on fall (11th), sample synchronised data. 0 -> WAIT_IDLE; 1 -> FAIL code 11.
- WAIT_IDLE: wait until filtered clock=1 and data=1. Then pulse done, busy=0, enter IDLE.
- Timer: XFER_TIMEOUT_MS (56000 cycles) runs from the first fall through WAIT_IDLE. Expiry at any point forces FAIL code 10.
- FAIL: both oe=0, error pulses 1 cycle, busy=0, enter IDLE.
- Timeout checks have priority over a fall arriving in the same cycle.
- done and error are never high together.
- Counter widths: derived from the parameters via $clog2. No wrap-around while active, because the counter stops at the terminal value.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding (IDLE, INHIBIT, WAIT_FIRST, SHIFT, ACK, WAIT_IDLE, FAIL)
  - errcode constants
  - cycle-count constants derived from CLK_KHZ
  - command byte constants (0xED, 0xF4, 0xFF); these are reused by the receivers.
- Sub-module ps2_line_filter: synchroniser, deglitch and fall-edge detect. It is shared with the receivers.

Test Plan:
- send din=0xED, device model clocks at 12 kHz and acks -> data bits on falls 1..8 = 1,0,1,1,0,1,1,1; parity=1; stop=1; done pulses once; errcode=00; busy total about 1.2 ms.
- send 0xF4 -> parity bit=0 on fall 9; clock held low exactly 3360 cycles before the start bit.
- Device model never clocks -> error at 420000±2 cycles after clock release; errcode=01; both oe=0.
- Device clocks 11 edges but leaves data high on the 11th -> error with errcode=11, no done. Device stops after 5 edges -> errcode=10 at 56000 cycles after the first fall.
- Second send mid-transfer is ignored (byte unchanged). A 3-cycle low glitch on ps2clk_in is not counted as an edge.
- rst_n asserted during SHIFT -> oe=0 immediately, busy=0. A following send of 0xFF completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the PS/2 receivers.
//   - transmitter FSM state encoding
//   - error codes reported on errcode
//   - helpers that turn microseconds/milliseconds into clock cycles, plus defaults for 28 MHz
//   - common command bytes sent to keyboards and mice
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StWaitFirst,
      StShift,
      StAck,
      StWaitIdle,
      StFail
   } ps2_tx_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_START_TO = 2'b01;
   localparam logic [1:0] ERR_XFER_TO  = 2'b10;
   localparam logic [1:0] ERR_NO_ACK   = 2'b11;

   function automatic int unsigned us_to_cycles(input int unsigned clk_khz,
                                                input int unsigned us);
      return (clk_khz * us) / 1000;
   endfunction

   function automatic int unsigned ms_to_cycles(input int unsigned clk_khz,
                                                input int unsigned ms);
      return clk_khz * ms;
   endfunction

   localparam int unsigned DEF_CLK_KHZ       = 28000;
   localparam int unsigned DEF_INHIBIT_CYC   = us_to_cycles(DEF_CLK_KHZ, 120);  // 3360
   localparam int unsigned DEF_START_TO_CYC  = ms_to_cycles(DEF_CLK_KHZ, 15);   // 420000
   localparam int unsigned DEF_XFER_TO_CYC   = ms_to_cycles(DEF_CLK_KHZ, 2);    // 56000

   localparam logic [7:0] CMD_SET_LEDS     = 8'hED;
   localparam logic [7:0] CMD_MOUSE_ENABLE = 8'hF4;
   localparam logic [7:0] CMD_RESET        = 8'hFF;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions the raw PS/2 clock and data pins.
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_clk_raw    raw PS/2 clock pin level
//   i_data_raw   raw PS/2 data pin level
//   o_clk_filt   synchronised and deglitched clock level
//   o_data_sync  synchronised data level
//   o_fall       one-cycle pulse when o_clk_filt goes 1->0
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clk_raw,
   input  logic i_data_raw,
   output logic o_clk_filt,
   output logic o_data_sync,
   output logic o_fall
);

   localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [1:0]       r_clk_sync;
   logic [1:0]       r_data_sync;
   logic             r_clk_filt;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   // Idle bus is high, so everything resets to 1 to avoid a fake edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_filt  <= 1'b1;
         r_fall      <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
         r_data_sync <= {r_data_sync[0], i_data_raw};
         r_fall      <= 1'b0;
         // r_cnt counts consecutive samples that disagree with the filtered level;
         // any agreeing sample restarts the count, so short glitches never get through.
         if (r_clk_sync[1] == r_clk_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_clk_filt <= r_clk_sync[1];
            r_fall     <= ~r_clk_sync[1];
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_clk_filt  = r_clk_filt;
   assign o_data_sync = r_data_sync[1];
   assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one byte from the host to a PS/2 device over the open-drain clock/data
// pair (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ack).
//   clk, rst_n            system clock, asynchronous active-low reset
//   din, send             byte to send and its one-cycle start strobe
//   ps2clk_in/ps2data_in  raw pin levels
//   ps2clk_oe/ps2data_oe  1 = pull the line low, 0 = release
//   busy                  transfer in progress
//   done / error          one-cycle completion / failure pulses
//   errcode               00 none, 01 start timeout, 10 transfer timeout, 11 no ack
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_KHZ          = 28000,
   parameter int unsigned INHIBIT_US       = 120,
   parameter int unsigned START_TIMEOUT_MS = 15,
   parameter int unsigned XFER_TIMEOUT_MS  = 2,
   parameter int unsigned FILTER_LEN       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       send,
   input  logic       ps2clk_in,
   input  logic       ps2data_in,
   output logic       ps2clk_oe,
   output logic       ps2data_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] errcode
);

   localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_KHZ, INHIBIT_US);
   localparam int unsigned START_CYC   = ms_to_cycles(CLK_KHZ, START_TIMEOUT_MS);
   localparam int unsigned XFER_CYC    = ms_to_cycles(CLK_KHZ, XFER_TIMEOUT_MS);
   localparam int unsigned CNT_MAX     = (START_CYC > INHIBIT_CYC) ? START_CYC : INHIBIT_CYC;
   localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
   localparam int unsigned XFER_W      = $clog2(XFER_CYC + 1);

   localparam logic [CNT_W-1:0]  INHIBIT_END  = CNT_W'(INHIBIT_CYC);
   localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0]  START_LAST   = CNT_W'(START_CYC - 1);
   localparam logic [XFER_W-1:0] XFER_LAST    = XFER_W'(XFER_CYC - 1);

   logic w_clk_filt;
   logic w_data_sync;
   logic w_fall;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clk_raw   (ps2clk_in),
      .i_data_raw  (ps2data_in),
      .o_clk_filt  (w_clk_filt),
      .o_data_sync (w_data_sync),
      .o_fall      (w_fall)
   );

   ps2_tx_state_e     r_state, w_state_d;
   logic [7:0]        r_byte, w_byte_d;
   logic              r_parity, w_parity_d;
   logic [3:0]        r_bitcnt, w_bitcnt_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic [XFER_W-1:0] r_xfer, w_xfer_d;
   logic              r_clk_oe, w_clk_oe_d;
   logic              r_data_oe, w_data_oe_d;
   logic              r_busy, w_busy_d;
   logic              r_done, w_done_d;
   logic              r_error, w_error_d;
   logic [1:0]        r_errcode, w_errcode_d;
   logic              w_fail;
   logic [1:0]        w_fail_code;
   logic              w_xfer_expired;

   always_comb begin
      w_state_d      = r_state;
      w_byte_d       = r_byte;
      w_parity_d     = r_parity;
      w_bitcnt_d     = r_bitcnt;
      w_cnt_d        = r_cnt;
      w_xfer_d       = r_xfer;
      w_clk_oe_d     = r_clk_oe;
      w_data_oe_d    = r_data_oe;
      w_busy_d       = r_busy;
      w_done_d       = 1'b0;
      w_error_d      = 1'b0;
      w_errcode_d    = r_errcode;
      w_fail         = 1'b0;
      w_fail_code    = ERR_NONE;
      w_xfer_expired = (r_xfer == XFER_LAST);

      unique case (r_state)
         StIdle: begin
            if (send) begin
               w_byte_d    = din;
               w_parity_d  = ~^din;
               w_errcode_d = ERR_NONE;
               w_cnt_d     = '0;
               w_clk_oe_d  = 1'b1;
               w_data_oe_d = 1'b0;
               w_busy_d    = 1'b1;
               w_state_d   = StInhibit;
            end
         end

         // Clock held low for INHIBIT_CYC cycles, start bit in the last inhibit cycle,
         // clock released one cycle later.
         StInhibit: begin
            if (r_cnt == INHIBIT_END) begin
               w_clk_oe_d = 1'b0;
               w_cnt_d    = '0;
               w_state_d  = StWaitFirst;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
               if (r_cnt == INHIBIT_LAST) begin
                  w_data_oe_d = 1'b1;
               end
            end
         end

         StWaitFirst: begin
            if (r_cnt == START_LAST) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_START_TO;
            end else if (w_fall) begin
               w_data_oe_d = ~r_byte[0];
               w_bitcnt_d  = 4'd1;
               w_xfer_d    = '0;
               w_state_d   = StShift;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end

         StShift: begin
            if (w_xfer_expired) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_XFER_TO;
            end else begin
               w_xfer_d = r_xfer + XFER_W'(1);
               if (w_fall) begin
                  w_bitcnt_d = r_bitcnt + 4'd1;
                  case (r_bitcnt)
                     4'd8: w_data_oe_d = ~r_parity;
                     4'd9: begin
                        // Stop bit: release data, the next fall carries the ack.
                        w_data_oe_d = 1'b0;
                        w_state_d   = StAck;
                     end
                     default: w_data_oe_d = ~r_byte[r_bitcnt[2:0]];
                  endcase
               end
            end
         end

         StAck: begin
            if (w_xfer_expired) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_XFER_TO;
            end else begin
               w_xfer_d = r_xfer + XFER_W'(1);
               if (w_fall) begin
                  if (!w_data_sync) begin
                     w_state_d = StWaitIdle;
                  end else begin
                     w_fail      = 1'b1;
                     w_fail_code = ERR_NO_ACK;
                  end
               end
            end
         end

         StWaitIdle: begin
            if (w_xfer_expired) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_XFER_TO;
            end else begin
               w_xfer_d = r_xfer + XFER_W'(1);
               if (w_clk_filt && w_data_sync) begin
                  w_done_d  = 1'b1;
                  w_busy_d  = 1'b0;
                  w_state_d = StIdle;
               end
            end
         end

         StFail: begin
            w_error_d = 1'b1;
            w_busy_d  = 1'b0;
            w_state_d = StIdle;
         end

         default: begin
            w_clk_oe_d  = 1'b0;
            w_data_oe_d = 1'b0;
            w_busy_d    = 1'b0;
            w_state_d   = StIdle;
         end
      endcase

      // Lines are released on the same edge the failure is detected.
      if (w_fail) begin
         w_clk_oe_d  = 1'b0;
         w_data_oe_d = 1'b0;
         w_errcode_d = w_fail_code;
         w_state_d   = StFail;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_byte    <= '0;
         r_parity  <= 1'b0;
         r_bitcnt  <= '0;
         r_cnt     <= '0;
         r_xfer    <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_errcode <= ERR_NONE;
      end else begin
         r_state   <= w_state_d;
         r_byte    <= w_byte_d;
         r_parity  <= w_parity_d;
         r_bitcnt  <= w_bitcnt_d;
         r_cnt     <= w_cnt_d;
         r_xfer    <= w_xfer_d;
         r_clk_oe  <= w_clk_oe_d;
         r_data_oe <= w_data_oe_d;
         r_busy    <= w_busy_d;
         r_done    <= w_done_d;
         r_error   <= w_error_d;
         r_errcode <= w_errcode_d;
      end
   end

   assign ps2clk_oe  = r_clk_oe;
   assign ps2data_oe = r_data_oe;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign errcode    = r_errcode;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2 device.
// The DUT runs at a scaled 1 MHz clock so the timeouts fit a short run:
// inhibit 120 cycles, start timeout 15000 cycles, transfer timeout 2000 cycles.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH       = 120;    // 120 us at 1000 kHz
   localparam int START_CYC = 15000;  // 15 ms at 1000 kHz
   localparam int XFER_CYC  = 2000;   // 2 ms at 1000 kHz
   localparam int HALF      = 40;     // device clock half period in system cycles

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       send;
   logic       ps2clk_in;
   logic       ps2data_in;
   logic       ps2clk_oe;
   logic       ps2data_oe;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] errcode;

   logic dev_clk;
   logic dev_data;
   logic glitch;

   int checks;
   int failures;
   int cyc;
   int n_done;
   int n_err;
   int n_both;

   // Open-drain bus: low if either side pulls it.
   assign ps2clk_in  = ~ps2clk_oe & dev_clk & ~glitch;
   assign ps2data_in = ~ps2data_oe & dev_data;

   ps2_host_tx #(
      .CLK_KHZ          (1000),
      .INHIBIT_US       (120),
      .START_TIMEOUT_MS (15),
      .XFER_TIMEOUT_MS  (2),
      .FILTER_LEN       (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .send       (send),
      .ps2clk_in  (ps2clk_in),
      .ps2data_in (ps2data_in),
      .ps2clk_oe  (ps2clk_oe),
      .ps2data_oe (ps2data_oe),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .errcode    (errcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      n_done = 0;
      n_err  = 0;
      n_both = 0;
   end
   always @(negedge clk) begin
      if (done) n_done = n_done + 1;
      if (error) n_err = n_err + 1;
      if (done && error) n_both = n_both + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no end of test, required end before 5 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue send and follow the inhibit / request-to-send sequence up to clock release.
   task automatic host_start(input logic [7:0] b);
      int n;
      din  = b;
      send = 1'b1;
      check("busy_before_send", busy, 1'b0);
      tick();
      send = 1'b0;
      check("busy_after_send", busy, 1'b1);
      check("errcode_cleared", errcode, 2'b00);
      n = 0;
      while (ps2clk_oe && !ps2data_oe && n < INH + 50) begin
         tick();
         n++;
      end
      check("inhibit_len", n, INH);
      check("start_bit_clk_still_low", ps2clk_oe, 1'b1);
      check("start_bit", ps2data_oe, 1'b1);
      tick();
      check("clk_released", ps2clk_oe, 1'b0);
      check("start_bit_held", ps2data_oe, 1'b1);
   endtask

   // Device clocks n_edges pulses, sampling data just before each rising edge.
   task automatic dev_clock(input int n_edges, input bit do_ack, input int glitch_at,
                            input int send_at, output logic [9:0] smp, output int t_first);
      smp     = '1;
      t_first = cyc;
      for (int k = 1; k <= n_edges; k++) begin
         dev_clk = 1'b0;
         if (k == 1) t_first = cyc;
         repeat (HALF) tick();
         if (k <= 10) smp[k-1] = ps2data_in;
         dev_clk = 1'b1;
         if (k == 10 && do_ack) dev_data = 1'b0;
         if (k == send_at) begin
            din  = 8'h00;
            send = 1'b1;
            tick();
            send = 1'b0;
            check("busy_mid_transfer", busy, 1'b1);
         end
         if (k == glitch_at) begin
            repeat (10) tick();
            glitch = 1'b1;
            repeat (3) tick();
            glitch = 1'b0;
         end
         repeat (HALF) tick();
         if (k == 11) dev_data = 1'b1;
      end
      dev_data = 1'b1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      check("done_seen", done, 1'b1);
      check("busy_low_with_done", busy, 1'b0);
   endtask

   initial begin
      logic [9:0] smp;
      int         t_first;
      int         n;
      int         d0;
      int         e0;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      din      = 8'h00;
      send     = 1'b0;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      glitch   = 1'b0;
      repeat (3) tick();
      check("rst_clk_oe", ps2clk_oe, 1'b0);
      check("rst_data_oe", ps2data_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_errcode", errcode, 2'b00);
      rst_n = 1'b1;
      repeat (5) tick();

      // 0xED with an ignored second send of 0x00 in the middle.
      d0 = n_done;
      e0 = n_err;
      host_start(8'hED);
      repeat (20) tick();
      dev_clock(11, 1'b1, 0, 3, smp, t_first);
      wait_done();
      repeat (20) tick();
      check("ed_data_bits", smp[7:0], 8'hED);
      check("ed_parity", smp[8], 1'b1);
      check("ed_stop", smp[9], 1'b1);
      check("ed_done_once", n_done - d0, 1);
      check("ed_no_error", n_err - e0, 0);
      check("ed_errcode", errcode, 2'b00);

      // 0xF4 with a 3-cycle low glitch on the clock pin.
      d0 = n_done;
      host_start(8'hF4);
      repeat (20) tick();
      dev_clock(11, 1'b1, 4, 0, smp, t_first);
      wait_done();
      repeat (20) tick();
      check("f4_data_bits", smp[7:0], 8'hF4);
      check("f4_parity", smp[8], 1'b0);
      check("f4_stop", smp[9], 1'b1);
      check("f4_done_once", n_done - d0, 1);

      // Device never clocks: start timeout.
      e0 = n_err;
      host_start(8'hFF);
      n = 0;
      while (!error && n < START_CYC + 100) begin
         tick();
         n++;
      end
      check("start_to_latency_ok", (n >= START_CYC - 2) && (n <= START_CYC + 2), 1'b1);
      check("start_to_errcode", errcode, 2'b01);
      check("start_to_clk_oe", ps2clk_oe, 1'b0);
      check("start_to_data_oe", ps2data_oe, 1'b0);
      check("start_to_busy", busy, 1'b0);
      repeat (5) tick();
      check("start_to_errcode_held", errcode, 2'b01);
      check("start_to_error_once", n_err - e0, 1);

      // Device clocks 11 edges but never acks.
      d0 = n_done;
      e0 = n_err;
      host_start(8'hED);
      repeat (20) tick();
      dev_clock(11, 1'b0, 0, 0, smp, t_first);
      repeat (50) tick();
      check("noack_errcode", errcode, 2'b11);
      check("noack_error_once", n_err - e0, 1);
      check("noack_no_done", n_done - d0, 0);
      check("noack_busy", busy, 1'b0);

      // Device stops after 5 edges: transfer timeout measured from the first pin fall.
      d0 = n_done;
      e0 = n_err;
      host_start(8'h55);
      repeat (20) tick();
      dev_clock(5, 1'b0, 0, 0, smp, t_first);
      n = 0;
      while (!error && n < XFER_CYC + 300) begin
         tick();
         n++;
      end
      check("xfer_to_seen", error, 1'b1);
      check("xfer_to_latency_ok",
            ((cyc - t_first) >= XFER_CYC) && ((cyc - t_first) <= XFER_CYC + 20), 1'b1);
      check("xfer_to_errcode", errcode, 2'b10);
      check("xfer_to_no_done", n_done - d0, 0);
      check("xfer_to_data_oe", ps2data_oe, 1'b0);

      // Reset in the middle of the data bits.
      host_start(8'hED);
      repeat (20) tick();
      dev_clock(4, 1'b0, 0, 0, smp, t_first);
      rst_n = 1'b0;
      #1;
      check("midrst_clk_oe", ps2clk_oe, 1'b0);
      check("midrst_data_oe", ps2data_oe, 1'b0);
      check("midrst_busy", busy, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();

      // 0xFF after the reset completes normally.
      d0 = n_done;
      e0 = n_err;
      host_start(8'hFF);
      repeat (20) tick();
      dev_clock(11, 1'b1, 0, 0, smp, t_first);
      wait_done();
      repeat (20) tick();
      check("ff_data_bits", smp[7:0], 8'hFF);
      check("ff_parity", smp[8], 1'b1);
      check("ff_stop", smp[9], 1'b1);
      check("ff_done_once", n_done - d0, 1);
      check("ff_no_error", n_err - e0, 0);
      check("ff_errcode", errcode, 2'b00);

      check("done_error_never_together", n_both, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
